// File: rtl/layer_output_serializer.sv
// Double-buffered serializer: captures one activation per neuron lane in any order,
// then replays the completed frame lane 0 first on a single serial output bus.
module layer_output_serializer #(
  parameter int numNeurons = 30,
  parameter int inWidth    = 16,
  parameter int outWidth   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [numNeurons-1:0]         x_valid,
  input  logic [numNeurons*inWidth-1:0] x_in,
  output logic [outWidth-1:0]           out_data,
  output logic                          out_valid,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          overflow
);

  localparam int IDX_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeurons - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx;
  logic [numNeurons-1:0] mask;
  logic [inWidth-1:0]    cap  [numNeurons];
  logic [inWidth-1:0]    strm [numNeurons];
  logic                  mask_full, xfer, last;

  assign mask_full = &mask;
  assign busy      = (state == STREAM) | mask_full;

  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (mask_full) begin
          xfer       = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (idx == LAST_IDX) begin
          last = 1'b1;
          if (mask_full) xfer = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      mask       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < numNeurons; i++) begin
        cap[i]  <= '0;
        strm[i] <= '0;
      end
    end else begin
      state <= state_next;

      // Lanes arriving on a transfer cycle land in the freshly cleared capture bank.
      mask <= xfer ? x_valid : (mask | x_valid);
      for (int unsigned i = 0; i < numNeurons; i++) begin
        if (x_valid[i] && (xfer || !mask[i]))
          cap[i] <= x_in[i*inWidth +: inWidth];
      end
      if (!xfer && |(x_valid & mask))
        overflow <= 1'b1;

      if (xfer) begin
        for (int unsigned i = 0; i < numNeurons; i++)
          strm[i] <= cap[i];
      end

      // Leaving IDLE emits lane 0 straight from the capture bank so the first
      // element appears on the transfer edge; idx then points at the next lane.
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (xfer) begin
            out_data  <= outWidth'(cap[0]);
            out_valid <= 1'b1;
            idx       <= IDX_W'(1);
          end else begin
            out_valid <= 1'b0;
          end
        end
        STREAM: begin
          out_data   <= outWidth'(strm[idx]);
          out_valid  <= 1'b1;
          frame_done <= last;
          idx        <= last ? '0 : idx + IDX_W'(1);
        end
        default: begin
          out_valid  <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer (4 lanes, 8-bit in, 16-bit out): vector table
// plus hand sequences, with a queue scoreboard checked on every valid output.
module tb_layer_output_serializer;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int OW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    x_valid;
  logic [N*IW-1:0] x_in;
  logic [OW-1:0]   out_data;
  logic            out_valid, frame_done, busy, overflow;

  layer_output_serializer #(.numNeurons(N), .inWidth(IW), .outWidth(OW)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
    .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        fd;
  } exp_t;

  typedef struct packed {
    logic [31:0] vals;     // lane i at [i*8 +: 8]
    logic [7:0]  ord;      // j-th arriving lane at [j*2 +: 2]
    logic        stagger;
    logic [63:0] exp;      // expected out_data for lane i at [i*16 +: 16]
  } vec_t;

  exp_t q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [63:0] e);
    exp_t x;
    for (int i = 0; i < N; i++) begin
      x.d  = e[i*16 +: 16];
      x.fd = (i == N-1);
      q.push_back(x);
    end
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 32'(q.size()), 32'd0);
    tick();
    tick();
    chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end else if (frame_done) begin
      chk("frame_done_without_valid", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt [4];
  int unsigned fd_cnt;

  initial begin
    vt[0] = '{vals: 32'h44332211, ord: 8'h00, stagger: 1'b0, exp: 64'h0044_0033_0022_0011};
    vt[1] = '{vals: 32'hD4C3B2A1, ord: 8'h63, stagger: 1'b1, exp: 64'h00D4_00C3_00B2_00A1};
    vt[2] = '{vals: 32'h807F01FF, ord: 8'h00, stagger: 1'b0, exp: 64'h0080_007F_0001_00FF};
    vt[3] = '{vals: 32'h12345678, ord: 8'hE4, stagger: 1'b1, exp: 64'h0012_0034_0056_0078};

    rst = 1'b1; x_valid = '0; x_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    for (int v = 0; v < 4; v++) begin
      x_in = vt[v].vals;
      if (!vt[v].stagger) begin
        x_valid = '1;
        push_frame(vt[v].exp);
        tick();
        x_valid = '0;
      end else begin
        for (int j = 0; j < N; j++) begin
          x_valid = '0;
          x_valid[vt[v].ord[j*2 +: 2]] = 1'b1;
          if (j == N-1) push_frame(vt[v].exp);
          tick();
          x_valid = '0;
          if (j < N-1) begin
            chk("stagger_no_valid", 32'(out_valid), 32'd0);
            chk("stagger_no_busy", 32'(busy), 32'd0);
          end
        end
      end
      drain("vec");
    end

    // Back-to-back: second frame complete while the first is streaming.
    x_in = 32'h04030201; x_valid = '1;
    push_frame(64'h0004_0003_0002_0001);
    tick();
    chk("b2b_busy_0", 32'(busy), 32'd1);
    x_in = 32'h08070605;
    push_frame(64'h0008_0007_0006_0005);
    tick();
    x_valid = '0;
    fd_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      chk("b2b_valid", 32'(out_valid), 32'd1);
      if (c <= 7) chk("b2b_busy", 32'(busy), 32'd1);
      if (frame_done) fd_cnt++;
      tick();
    end
    chk("b2b_frame_done_count", fd_cnt, 32'd2);
    chk("b2b_valid_after", 32'(out_valid), 32'd0);
    drain("b2b");

    // Lane 2 written twice before the frame completes.
    x_in = 32'h00050000; x_valid = 4'b0100;
    tick();
    x_in = 32'h00090000; x_valid = 4'b0100;
    tick();
    x_valid = '0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_no_busy", 32'(busy), 32'd0);
    x_in = 32'h4D002B1A; x_valid = 4'b1011;
    push_frame(64'h004D_0005_002B_001A);
    tick();
    x_valid = '0;
    drain("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset after the second element of a frame has been emitted.
    x_in = 32'h0C0B0A09; x_valid = '1;
    q.push_back('{d: 16'h0009, fd: 1'b0});
    q.push_back('{d: 16'h000A, fd: 1'b0});
    tick();
    x_valid = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_queue", 32'(q.size()), 32'd0);
    tick();
    x_in = 32'hDDCCBBAA; x_valid = '1;
    push_frame(64'h00DD_00CC_00BB_00AA);
    tick();
    x_valid = '0;
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
